// File: rtl/input_stream_loader.sv
// rtl/input_stream_loader.sv - valid/ready stream to DEPTH x CH input buffer write sequencer
// Word address walks 0..DEPTH-1 per channel, channels 0..CH-1 per frame; single or continuous framing.
module input_stream_loader #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 9,
  parameter int CH     = 1,
  parameter int ADDR_W = $clog2(DEPTH),
  parameter int CH_W   = (CH > 1) ? $clog2(CH) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              mode,
  input  logic              abort,
  input  logic              full,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              wr,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [CH_W-1:0]   wr_ch,
  output logic [DATA_W-1:0] wr_data,
  output logic              busy,
  output logic              done,
  output logic [15:0]       frame_cnt
);

  typedef enum logic {S_IDLE, S_LOAD} state_e;

  localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(DEPTH - 1);
  localparam logic [CH_W-1:0]   CH_LAST   = CH_W'(CH - 1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [CH_W-1:0]   ch_q, ch_d;
  logic              mode_q, mode_d;
  logic              done_q, done_d;
  logic [15:0]       frame_cnt_q, frame_cnt_d;
  logic              accept;
  logic              last_addr;
  logic              last_ch;

  // Handshake is combinational so a word is written in the same cycle it is offered.
  assign in_ready  = (state_q == S_LOAD) && !full && !abort;
  assign accept    = in_ready && in_valid;
  assign wr        = accept;
  assign wr_addr   = addr_q;
  assign wr_ch     = ch_q;
  assign wr_data   = in_data;
  assign busy      = (state_q == S_LOAD);
  assign done      = done_q;
  assign frame_cnt = frame_cnt_q;

  assign last_addr = (addr_q == ADDR_LAST);
  assign last_ch   = (ch_q == CH_LAST);

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    ch_d        = ch_q;
    mode_d      = mode_q;
    frame_cnt_d = frame_cnt_q;
    done_d      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start && !abort) begin
          state_d     = S_LOAD;
          addr_d      = '0;
          ch_d        = '0;
          frame_cnt_d = '0;
          mode_d      = mode;
        end
      end
      S_LOAD: begin
        if (abort) begin
          state_d = S_IDLE;
          addr_d  = '0;
          ch_d    = '0;
        end else if (accept) begin
          if (!last_addr) begin
            addr_d = addr_q + ADDR_W'(1);
          end else begin
            addr_d = '0;
            if (!last_ch) begin
              ch_d = ch_q + CH_W'(1);
            end else begin
              // Frame end: continuous mode rolls straight into the next frame.
              ch_d        = '0;
              frame_cnt_d = frame_cnt_q + 16'd1;
              done_d      = 1'b1;
              if (!mode_q) state_d = S_IDLE;
            end
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      ch_q        <= '0;
      mode_q      <= 1'b0;
      done_q      <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      ch_q        <= ch_d;
      mode_q      <= mode_d;
      done_q      <= done_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

endmodule

// File: tb/tb_input_stream_loader.sv
// tb/tb_input_stream_loader.sv - directed and randomized checks of input_stream_loader against a frame-index model
module tb_input_stream_loader;
  localparam int DW    = 8;
  localparam int DEPTH = 9;
  localparam int CH    = 2;
  localparam int AW    = $clog2(DEPTH);
  localparam int CW    = (CH > 1) ? $clog2(CH) : 1;
  localparam int FW    = DEPTH * CH;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0, mode = 1'b0, abort = 1'b0, full = 1'b0, in_valid = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          in_ready, wr, busy, done;
  logic [AW-1:0] wr_addr;
  logic [CW-1:0] wr_ch;
  logic [DW-1:0] wr_data;
  logic [15:0]   frame_cnt;

  input_stream_loader #(.DATA_W(DW), .DEPTH(DEPTH), .CH(CH)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .abort(abort), .full(full),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready), .wr(wr), .wr_addr(wr_addr),
    .wr_ch(wr_ch), .wr_data(wr_data), .busy(busy), .done(done), .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  // Model: frame position as a single word index k in 0..DEPTH*CH-1.
  bit m_busy, m_mode, m_done, m_acc;
  int m_k, m_frames;
  int cyc;

  int wr_cnt, busy_cnt;
  int cap[$];
  int done_cyc[$];
  bit e_rdy, e_wr;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  initial begin
    m_busy = 0; m_mode = 0; m_done = 0; m_k = 0; m_frames = 0; cyc = 0;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_busy = 0; m_mode = 0; m_done = 0; m_k = 0; m_frames = 0;
      end else begin
        cyc++;
        m_acc  = m_busy && !full && !abort && in_valid;
        m_done = 0;
        if (!m_busy) begin
          if (start && !abort) begin
            m_busy = 1; m_k = 0; m_frames = 0; m_mode = mode;
          end
        end else if (abort) begin
          m_busy = 0; m_k = 0;
        end else if (m_acc) begin
          if (m_k == FW - 1) begin
            m_k = 0; m_frames = (m_frames + 1) % 65536; m_done = 1;
            if (!m_mode) m_busy = 0;
          end else begin
            m_k++;
          end
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      e_rdy = m_busy && !full && !abort;
      e_wr  = e_rdy && in_valid;
      check("in_ready", 32'(in_ready), 32'(e_rdy));
      check("wr", 32'(wr), 32'(e_wr));
      check("busy", 32'(busy), 32'(m_busy));
      check("done", 32'(done), 32'(m_done));
      check("frame_cnt", 32'(frame_cnt), 32'(m_frames));
      check("wr_addr", 32'(wr_addr), 32'(m_k % DEPTH));
      check("wr_ch", 32'(wr_ch), 32'(m_k / DEPTH));
      if (e_wr) check("wr_data", 32'(wr_data), 32'(in_data));
      if (wr === 1'b1) begin
        wr_cnt++;
        cap.push_back(int'(wr_ch) * DEPTH + int'(wr_addr));
      end
      if (busy === 1'b1) busy_cnt++;
      if (done === 1'b1) done_cyc.push_back(cyc);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    in_data = DW'($urandom);
  endtask

  task automatic clear_log();
    cap.delete();
    done_cyc.delete();
    wr_cnt = 0;
    busy_cnt = 0;
  endtask

  task automatic kick(input logic m, output int s);
    clear_log();
    s = cyc;
    start = 1; mode = m; abort = 0; full = 0; in_valid = 1;
    step();
    start = 0;
  endtask

  task automatic check_seq(input string name, input int n);
    check({name, "_len"}, 32'(cap.size()), 32'(n));
    for (int i = 0; i < cap.size() && i < n; i++) check(name, 32'(cap[i]), 32'(i % FW));
  endtask

  int s;

  initial begin
    wr_cnt = 0; busy_cnt = 0;
    #1;
    check("rst_busy", 32'(busy), 32'(0));
    check("rst_wr", 32'(wr), 32'(0));
    check("rst_frame_cnt", 32'(frame_cnt), 32'(0));
    step(); step();
    rst_n = 1;
    step();

    // Single frame, no back-pressure
    kick(1'b0, s);
    for (int r = 1; r <= 20; r++) step();
    check("t1_writes", 32'(wr_cnt), 32'(18));
    check_seq("t1_seq", 18);
    check("t1_done_n", 32'(done_cyc.size()), 32'(1));
    if (done_cyc.size() > 0) check("t1_done_cyc", 32'(done_cyc[0] - s), 32'(19));
    check("t1_busy", 32'(busy), 32'(0));
    check("t1_frame_cnt", 32'(frame_cnt), 32'(1));
    check("t1_model_frames", 32'(m_frames), 32'(1));

    // Full on writes 4-6
    kick(1'b0, s);
    for (int r = 1; r <= 24; r++) begin
      full = (r >= 4 && r <= 6);
      if (r == 5) check("t2_addr_hold", 32'(wr_addr), 32'(3));
      step();
    end
    full = 0;
    check("t2_writes", 32'(wr_cnt), 32'(18));
    check_seq("t2_seq", 18);
    if (done_cyc.size() > 0) check("t2_done_cyc", 32'(done_cyc[0] - s), 32'(22));
    else check("t2_done_n", 32'(0), 32'(1));

    // Continuous mode, three frames, then abort
    kick(1'b1, s);
    for (int r = 1; r <= 55; r++) begin
      abort = (r == 55);
      step();
    end
    abort = 0;
    step(); step();
    check("t3_writes", 32'(wr_cnt), 32'(54));
    check("t3_busy_cycles", 32'(busy_cnt), 32'(55));
    check("t3_done_n", 32'(done_cyc.size()), 32'(3));
    for (int i = 0; i < done_cyc.size() && i < 3; i++)
      check("t3_done_cyc", 32'(done_cyc[i] - s), 32'(19 + 18 * i));
    check("t3_frame_cnt", 32'(frame_cnt), 32'(3));
    check_seq("t3_seq", 54);

    // Abort at ch=1, addr=5
    kick(1'b0, s);
    for (int r = 1; r <= 14; r++) step();
    check("t4_pre_addr", 32'(wr_addr), 32'(5));
    check("t4_pre_ch", 32'(wr_ch), 32'(1));
    abort = 1;
    #2;
    check("t4_abort_wr", 32'(wr), 32'(0));
    step();
    abort = 0;
    check("t4_idle", 32'(busy), 32'(0));
    step(); step();
    check("t4_writes", 32'(wr_cnt), 32'(14));
    check("t4_no_done", 32'(done_cyc.size()), 32'(0));
    check("t4_frame_cnt", 32'(frame_cnt), 32'(0));
    kick(1'b0, s);
    for (int r = 1; r <= 20; r++) step();
    check_seq("t4_reload_seq", 18);

    // in_valid on odd cycles only
    kick(1'b0, s);
    for (int r = 1; r <= 38; r++) begin
      in_valid = r[0];
      step();
    end
    in_valid = 0;
    check("t5_writes", 32'(wr_cnt), 32'(18));
    check_seq("t5_seq", 18);
    if (done_cyc.size() > 0) check("t5_done_cyc", 32'(done_cyc[0] - s), 32'(36));
    else check("t5_done_n", 32'(0), 32'(1));

    // Asynchronous reset mid-frame at addr 7
    kick(1'b0, s);
    for (int r = 1; r <= 7; r++) step();
    check("t6_pre_addr", 32'(wr_addr), 32'(7));
    #2;
    rst_n = 0;
    #1;
    check("t6_rst_wr", 32'(wr), 32'(0));
    check("t6_rst_ready", 32'(in_ready), 32'(0));
    check("t6_rst_busy", 32'(busy), 32'(0));
    check("t6_rst_addr", 32'(wr_addr), 32'(0));
    start = 1;
    step(); step();
    check("t6_start_ignored", 32'(busy), 32'(0));
    start = 0;
    rst_n = 1;
    step();
    kick(1'b0, s);
    for (int r = 1; r <= 20; r++) step();
    check_seq("t6_clean_seq", 18);
    check("t6_frame_cnt", 32'(frame_cnt), 32'(1));

    // Randomized traffic; the per-cycle compare process carries the checking
    for (int i = 0; i < 4000; i++) begin
      start    = ($urandom_range(7) == 0);
      mode     = $urandom_range(1);
      abort    = ($urandom_range(40) == 0);
      full     = ($urandom_range(3) == 0);
      in_valid = ($urandom_range(3) != 0);
      if ($urandom_range(600) == 0) begin
        #2;
        rst_n = 0;
        step();
        rst_n = 1;
      end else begin
        step();
      end
    end
    start = 0; abort = 0; full = 0; in_valid = 0;
    step(); step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
